// File: rtl/coord_scan_gen.sv
// coord_scan_gen: streams {y,x} grid coordinates over a band of rows
// starting at a programmable row, in raster or serpentine order, with a
// valid/ready handshake so the downstream datapath can stall the scan.
module coord_scan_gen #(
  parameter int X_SZ   = 4,
  parameter int Y_SZ   = 4,
  parameter int X_MIN  = 1,
  parameter int X_MAX  = 8,
  parameter int Y_MIN  = 1,
  parameter int Y_MAX  = 8,
  parameter int CNT_SZ = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [Y_SZ-1:0]      start_row_i,
  input  logic [CNT_SZ-1:0]    num_rows_i,
  input  logic                 mode_i,
  input  logic                 coord_ready_i,
  output logic                 coord_valid_o,
  output logic [X_SZ+Y_SZ-1:0] coord_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [X_SZ-1:0]   XLO  = X_SZ'(X_MIN);
  localparam logic [X_SZ-1:0]   XHI  = X_SZ'(X_MAX);
  localparam logic [Y_SZ-1:0]   YLO  = Y_SZ'(Y_MIN);
  localparam logic [Y_SZ-1:0]   YHI  = Y_SZ'(Y_MAX);
  localparam logic [CNT_SZ-1:0] ONE  = CNT_SZ'(1);
  localparam logic [CNT_SZ-1:0] ZERO = '0;

  state_t              state_q, state_d;
  logic [X_SZ-1:0]     x_q, x_d;
  logic [Y_SZ-1:0]     y_q, y_d;
  logic [CNT_SZ-1:0]   rows_q, rows_d;   // rows still to emit, incl. current
  logic                mode_q, mode_d;   // 1 = serpentine
  logic                dir_q, dir_d;     // 1 = current row runs X_MAX down to X_MIN
  logic                hs;
  logic                end_col;
  logic                nxt_dir;

  assign hs      = (state_q == SCAN) && coord_ready_i;
  assign end_col = dir_q ? (x_q == XLO) : (x_q == XHI);
  // Serpentine flips direction every row; raster always runs ascending.
  assign nxt_dir = mode_q & ~dir_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and scan-position logic; position only moves on a handshake.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rows_d  = rows_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SCAN;
          // Out-of-range start rows fall back to the first row.
          y_d     = ((start_row_i < YLO) || (start_row_i > YHI)) ? YLO : start_row_i;
          rows_d  = (num_rows_i == ZERO) ? ONE : num_rows_i;
          mode_d  = mode_i;
          dir_d   = 1'b0;
          x_d     = XLO;
        end
      end
      SCAN: begin
        if (hs) begin
          if (end_col) begin
            if (rows_q == ONE) begin
              state_d = DONE;
            end else begin
              rows_d = rows_q - ONE;
              y_d    = (y_q == YHI) ? YLO : y_q + 1'b1;
              dir_d  = nxt_dir;
              x_d    = nxt_dir ? XHI : XLO;
            end
          end else begin
            x_d = dir_q ? x_q - 1'b1 : x_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan position, row counter and latched mode.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      rows_q <= '0;
      mode_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      rows_q <= rows_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
    end
  end

  assign coord_o       = {y_q, x_q};
  assign coord_valid_o = (state_q == SCAN);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_coord_scan_gen.sv
// Scoreboard bench for coord_scan_gen: stimulus pushes expected coordinates,
// a negedge monitor pops and compares on each handshake.
module tb_coord_scan_gen;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] start_row_i = '0;
  logic [4:0] num_rows_i = '0;
  logic       mode_i = 1'b0;
  logic       coord_ready_i = 1'b1;
  logic       coord_valid_o;
  logic [7:0] coord_o;
  logic       busy_o;
  logic       done_o;

  coord_scan_gen dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_row_i(start_row_i),
    .num_rows_i(num_rows_i), .mode_i(mode_i), .coord_ready_i(coord_ready_i),
    .coord_valid_o(coord_valid_o), .coord_o(coord_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         hs_cnt = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         last_hs_cyc = -10;
  bit         bp = 1'b0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pc = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected sequence: row r of the band is ((sr-1+r) mod 8)+1; odd band rows
  // run 8..1 in serpentine mode, everything else runs 1..8.
  task automatic push_scan(int sr, int n, bit serp);
    logic [3:0] yy, xx;
    for (int r = 0; r < n; r++) begin
      yy = 4'(((sr - 1 + r) % 8) + 1);
      for (int i = 0; i < 8; i++) begin
        xx = (serp && (r % 2 == 1)) ? 4'(8 - i) : 4'(1 + i);
        exp_q.push_back({yy, xx});
      end
    end
  endtask

  task automatic issue(int sr, int nr, bit md);
    start_row_i = 4'(sr);
    num_rows_i  = 5'(nr);
    mode_i      = md;
    start_i     = 1'b1;
    @(posedge clk_i); #1;
    start_i     = 1'b0;
  endtask

  task automatic wait_done(int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(posedge clk_i); #1;
      if (done_o) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  // Ready driver: tied high unless back-pressure is enabled.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      coord_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare on handshakes, check hold under stall and done timing.
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("valid_hold", 32'(coord_valid_o), 32'd1);
        chk("coord_hold", 32'(coord_o), 32'(pc));
      end
      if (coord_valid_o && coord_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_coord actual=%0h expected=none", coord_o);
        end else begin
          chk("coord", 32'(coord_o), 32'(exp_q.pop_front()));
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        chk("done_timing", 32'(cyc - last_hs_cyc), 32'd1);
        chk("done_drained", 32'(exp_q.size()), 32'd0);
      end
      pv = coord_valid_o;
      pr = coord_ready_i;
      pc = coord_o;
    end
  end

  initial begin
    int h0, d0;
    bit ok;
    #1;
    chk("rst_valid", 32'(coord_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_coord", 32'(coord_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Raster basic: rows 3,4.
    push_scan(3, 2, 1'b0);
    issue(3, 2, 1'b0);
    chk("first_valid", 32'(coord_valid_o), 32'd1);
    chk("first_coord", 32'(coord_o), 32'h31);
    chk("busy_scan", 32'(busy_o), 32'd1);
    wait_done(40);
    chk("busy_done", 32'(busy_o), 32'd1);
    @(posedge clk_i); #1;

    // Serpentine with wrap: rows 8,1,2.
    push_scan(8, 3, 1'b1);
    issue(8, 3, 1'b1);
    wait_done(60);
    @(posedge clk_i); #1;

    // Back-pressure, raster rows 3,4.
    bp = 1'b1;
    push_scan(3, 2, 1'b0);
    issue(3, 2, 1'b0);
    wait_done(400);
    bp = 1'b0;
    @(posedge clk_i); #1;

    // num_rows = 0 -> one row; start_row = 0 -> row 1.
    push_scan(1, 1, 1'b0);
    issue(0, 0, 1'b0);
    wait_done(30);
    @(posedge clk_i); #1;

    // start_row = 12 -> row 1.
    push_scan(1, 1, 1'b1);
    issue(12, 1, 1'b1);
    wait_done(30);
    @(posedge clk_i); #1;

    // Reset after 5 accepted coordinates.
    push_scan(2, 2, 1'b0);
    h0 = hs_cnt;
    issue(2, 2, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (hs_cnt >= h0 + 5) ok = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    chk("five_coords_seen", 32'(ok), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(coord_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_coord", 32'(coord_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("no_done_after_rst", 32'(done_cnt), 32'(d0));
    chk("idle_after_rst", 32'(busy_o), 32'd0);
    push_scan(2, 1, 1'b0);
    issue(2, 1, 1'b0);
    chk("restart_coord", 32'(coord_o), 32'h21);
    wait_done(30);
    @(posedge clk_i); #1;

    // start pulsed during SCAN and during DONE is ignored.
    push_scan(5, 2, 1'b0);
    issue(5, 2, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    start_row_i = 4'd7; num_rows_i = 5'd3; mode_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(40);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("ignored_busy", 32'(busy_o), 32'd0);
    chk("ignored_valid", 32'(coord_valid_o), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
